// File: rtl/fc_neuron.sv
// fc_neuron: four-stage pipelined signed fixed-point dot product plus bias with floor shift and saturation
module fc_neuron #(
  parameter int N    = 30,
  parameter int W_W  = 16,
  parameter int D_W  = 24,
  parameter int O_W  = 32,
  parameter int FRAC = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic signed [W_W-1:0] i_weight [N],
  input  logic signed [D_W-1:0] i_data   [N],
  input  logic signed [W_W-1:0] i_bias,
  output logic signed [O_W-1:0] o_output
);
  localparam int P_W = W_W + D_W;
  localparam int A_W = P_W + $clog2(N + 1) + 1;
  localparam int NP  = 32;
  logic signed [P_W-1:0] prod [NP];
  logic signed [P_W-1:0] p    [NP];
  logic signed [A_W-1:0] s2   [8];
  logic signed [A_W-1:0] s3   [2];
  logic signed [A_W-1:0] s2_n [8];
  logic signed [A_W-1:0] s3_n [2];
  logic signed [A_W-1:0] b1, b2, b3, tot, sh;
  logic                  fits;
  // Lanes beyond N are tied to zero so the tree always sees 32 leaves
  for (genvar g = 0; g < NP; g++) begin : g_lane
    if (g < N) begin : g_mul
      assign prod[g] = i_weight[g] * i_data[g];
    end else begin : g_pad
      assign prod[g] = '0;
    end
  end
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      s2_n[j] = '0;
      for (int k = 0; k < 4; k++) s2_n[j] = s2_n[j] + A_W'(p[4*j+k]);
    end
    for (int j = 0; j < 2; j++) begin
      s3_n[j] = '0;
      for (int k = 0; k < 4; k++) s3_n[j] = s3_n[j] + s2[4*j+k];
    end
    tot  = s3[0] + s3[1] + b3;
    sh   = tot >>> FRAC;
    fits = (&sh[A_W-1:O_W-1]) | ~(|sh[A_W-1:O_W-1]);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NP; i++) p[i] <= '0;
      for (int j = 0; j < 8; j++) s2[j] <= '0;
      for (int j = 0; j < 2; j++) s3[j] <= '0;
      b1       <= '0;
      b2       <= '0;
      b3       <= '0;
      o_output <= '0;
    end else begin
      for (int i = 0; i < NP; i++) p[i] <= prod[i];
      for (int j = 0; j < 8; j++) s2[j] <= s2_n[j];
      for (int j = 0; j < 2; j++) s3[j] <= s3_n[j];
      b1       <= A_W'(i_bias) <<< FRAC;
      b2       <= b1;
      b3       <= b2;
      o_output <= fits ? sh[O_W-1:0] : {sh[A_W-1], {(O_W-1){~sh[A_W-1]}}};
    end
  end
endmodule

// File: tb/tb_fc_neuron.sv
// tb_fc_neuron: table vectors, random vectors against a real-valued model, latency and async reset checks
module tb_fc_neuron;
  localparam int N = 30;
  logic clk = 0;
  logic rst_n = 0;
  logic signed [15:0] w [N];
  logic signed [23:0] d [N];
  logic signed [15:0] b;
  logic signed [31:0] o;
  int checks = 0;
  int errors = 0;
  logic [31:0] hist [$];
  string names [$];
  typedef struct {
    logic [15:0] w0, wr;
    logic [23:0] d0, dr;
    logic [15:0] b;
    logic [31:0] e;
  } vec_t;
  vec_t tbl [9];

  fc_neuron dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_weight(w), .i_data(d), .i_bias(b), .o_output(o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Exact in double precision: every term is an integer scaled by a power of two below 2^53
  function automatic logic [31:0] model();
    real acc = 0.0;
    real f;
    for (int i = 0; i < N; i++) acc += real'(w[i]) * real'(d[i]);
    acc += real'(b) * 256.0;
    f = $floor(acc / 256.0);
    if (f > 2147483647.0) return 32'h7FFFFFFF;
    if (f < -2147483648.0) return 32'h80000000;
    return 32'($rtoi(f));
  endfunction

  // Inputs driven at negedge n appear on o_output at negedge n+4
  task automatic tick();
    @(negedge clk);
    if (hist.size() == 4) chk(names.pop_front(), o, hist.pop_front());
  endtask

  task automatic apply(vec_t v);
    for (int i = 0; i < N; i++) begin
      w[i] = (i == 0) ? v.w0 : v.wr;
      d[i] = (i == 0) ? v.d0 : v.dr;
    end
    b = v.b;
  endtask

  task automatic push(string nm, logic [31:0] e);
    hist.push_back(e);
    names.push_back(nm);
  endtask

  initial begin
    tbl[0] = '{16'h0100, 16'h0100, 24'h000100, 24'h000100, 16'h0000, 32'h00001E00};
    tbl[1] = '{16'hFF00, 16'hFF00, 24'h000200, 24'h000200, 16'h0080, 32'hFFFFC480};
    tbl[2] = '{16'h0001, 16'h0000, 24'h000001, 24'h000000, 16'h0000, 32'h00000000};
    tbl[3] = '{16'hFFFF, 16'h0000, 24'h000001, 24'h000000, 16'h0000, 32'hFFFFFFFF};
    tbl[4] = '{16'h7FFF, 16'h7FFF, 24'h7FFFFF, 24'h7FFFFF, 16'h7FFF, 32'h7FFFFFFF};
    tbl[5] = '{16'h8001, 16'h8001, 24'h7FFFFF, 24'h7FFFFF, 16'h7FFF, 32'h80000000};
    tbl[6] = '{16'h0000, 16'h0000, 24'h000000, 24'h000000, 16'h0080, 32'h00000080};
    tbl[7] = '{16'h0000, 16'h0000, 24'h000000, 24'h000000, 16'hFF80, 32'hFFFFFF80};
    tbl[8] = '{16'h8000, 16'h8000, 24'h800000, 24'h800000, 16'h0000, 32'h7FFFFFFF};
    apply(tbl[6]);
    #12 chk("reset_value", o, 32'h0);
    @(negedge clk);
    rst_n = 1;
    for (int t = 0; t < 9; t++) begin
      tick();
      apply(tbl[t]);
      push($sformatf("vec%0d", t), tbl[t].e);
    end
    for (int t = 0; t < 80; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (t % 2 == 0) begin
          w[i] = 16'($signed(11'($urandom)));
          d[i] = 24'($signed(15'($urandom)));
        end else begin
          w[i] = 16'($urandom);
          d[i] = 24'($urandom);
        end
      end
      b = 16'($urandom);
      push($sformatf("rand%0d", t), model());
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      apply(tbl[0]);
      push("steady", tbl[0].e);
    end
    hist.delete();
    names.delete();
    #2 chk("pre_reset", o, 32'h00001E00);
    rst_n = 0;
    #1 chk("async_reset", o, 32'h0);
    @(negedge clk);
    chk("held_reset", o, 32'h0);
    rst_n = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_hold%0d", k), o, 32'h0);
    end
    @(negedge clk);
    chk("post_reset_first", o, 32'h00001E00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
